ram_arbiter: RTL

Two-requester arbiter for the shared single-port `Ram` (DATA_W x DEPTH) in the CNN datapath. It lets the image loader and the convolution engine share the feature/weight memory. It grants the memory to one requester at a time in bursts, using round-robin priority and a burst-length cap for fairness. It drives the `Ram` rd/wr/adr/dataIn pins and returns registered read data with a valid strobe to the owning requester.

---
 rtl/ram_arbiter_if.sv | 30 +++
 rtl/ram_arbiter.sv | 107 ++++++++++
 2 files changed

// File: rtl/ram_arbiter_if.sv
// Requester-side and Ram-side signal bundle for ram_arbiter.
// slave is the arbiter's view; master is the requesters plus the Ram.
interface ram_arbiter_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
);
    logic              req0, req1;
    logic              wr0, wr1;
    logic [ADDR_W-1:0] adr0, adr1;
    logic [DATA_W-1:0] dataIn0, dataIn1;
    logic              gnt0, gnt1;
    logic              rdValid0, rdValid1;
    logic [DATA_W-1:0] rdData;
    logic              ramRd, ramWr;
    logic [ADDR_W-1:0] ramAdr;
    logic [DATA_W-1:0] ramDataIn;
    logic [DATA_W-1:0] ramDataOut;

    modport slave (
        input  req0, req1, wr0, wr1, adr0, adr1, dataIn0, dataIn1, ramDataOut,
        output gnt0, gnt1, rdValid0, rdValid1, rdData,
               ramRd, ramWr, ramAdr, ramDataIn
    );

    modport master (
        output req0, req1, wr0, wr1, adr0, adr1, dataIn0, dataIn1, ramDataOut,
        input  gnt0, gnt1, rdValid0, rdValid1, rdData,
               ramRd, ramWr, ramAdr, ramDataIn
    );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin, burst-capped arbiter sharing one single-port Ram between
// two requesters; returns registered read data with per-requester valid.
module ram_arbiter #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned MAX_BURST = 4
) (
    input logic           clk,
    input logic           rstN,
    ram_arbiter_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CAP = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t           state;
    logic             last;
    logic [CNT_W-1:0] cnt;

    logic             access0, access1, rd0, rd1;
    logic             own_req, oth_req, oth_idx, idle_win;
    logic [CNT_W-1:0] cnt_inc;

    // Grants come straight from the state flops, so reset drops them at once.
    assign bus.gnt0 = (state == OWN0);
    assign bus.gnt1 = (state == OWN1);

    assign access0 = bus.gnt0 & bus.req0;
    assign access1 = bus.gnt1 & bus.req1;
    assign rd0     = access0 & ~bus.wr0;
    assign rd1     = access1 & ~bus.wr1;

    assign bus.ramRd = rd0 | rd1;
    assign bus.ramWr = (access0 & bus.wr0) | (access1 & bus.wr1);

    always_comb begin
        bus.ramAdr    = ADDR_W'(0);
        bus.ramDataIn = DATA_W'(0);
        if (access0) begin
            bus.ramAdr    = bus.adr0;
            bus.ramDataIn = bus.dataIn0;
        end else if (access1) begin
            bus.ramAdr    = bus.adr1;
            bus.ramDataIn = bus.dataIn1;
        end
    end

    // Owner/other views of the request lines; tie in IDLE goes to the non-last side.
    always_comb begin
        own_req  = (state == OWN1) ? bus.req1 : bus.req0;
        oth_req  = (state == OWN1) ? bus.req0 : bus.req1;
        oth_idx  = (state == OWN0);
        idle_win = (bus.req0 & bus.req1) ? ~last : bus.req1;
        cnt_inc  = cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state        <= IDLE;
            last         <= 1'b1;
            cnt          <= '0;
            bus.rdValid0 <= 1'b0;
            bus.rdValid1 <= 1'b0;
            bus.rdData   <= '0;
        end else begin
            bus.rdValid0 <= rd0;
            bus.rdValid1 <= rd1;
            if (rd0 | rd1) bus.rdData <= bus.ramDataOut;

            case (state)
                IDLE: begin
                    if (bus.req0 | bus.req1) begin
                        state <= idle_win ? OWN1 : OWN0;
                        last  <= idle_win;
                        cnt   <= '0;
                    end
                end
                OWN0, OWN1: begin
                    if (own_req) begin
                        if (cnt_inc == CAP) begin
                            cnt <= '0;
                            if (oth_req) begin
                                state <= oth_idx ? OWN1 : OWN0;
                                last  <= oth_idx;
                            end
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end else begin
                        cnt <= '0;
                        if (oth_req) begin
                            state <= oth_idx ? OWN1 : OWN0;
                            last  <= oth_idx;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule
